// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word at a time from imem, hands {inst, inst_pc} to decode.
// Latency: request accepted in cycle N, response in cycle M>N -> inst_valid in cycle M+1 (3 cycles/inst with 1-cycle memory).
// Backpressure: a held instruction stays stable while inst_ready=0; no new request is issued until decode consumes it.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   imem_req_valid/ready/addr         fetch request channel (addr = pc)
//   imem_resp_valid/data              fetch response (only honoured while a fetch is outstanding)
//   inst_valid/ready, inst, inst_pc   instruction handshake to decode
//   redirect_valid/pc                 PC redirect from jal/jalr/branch resolution
//   fetch_err                         sticky flag: misaligned redirect target seen
module inst_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            discard_q, discard_d;
    logic            fetch_err_q, fetch_err_d;

    logic            redir_ok;
    logic            redir_bad;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        discard_d   = discard_q;
        fetch_err_d = fetch_err_q;

        if ((state_q != S_ERR) && redir_bad) begin
            // Misaligned target is fatal; any outstanding response is simply never honoured.
            fetch_err_d = 1'b1;
            discard_d   = 1'b0;
            state_d     = S_ERR;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redir_ok) begin
                        pc_d = redirect_pc;
                    end
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        // The request just accepted carried the old PC, so its data must be dropped.
                        discard_d = redir_ok;
                    end
                end
                S_WAIT: begin
                    if (redir_ok) begin
                        pc_d = redirect_pc;
                        if (imem_resp_valid) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            discard_d = 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            inst_d    = imem_resp_data;
                            inst_pc_d = pc_q;
                            pc_d      = pc_q + XLEN'(4);
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A redirect drops the held word whether or not decode takes it this cycle.
                    if (redir_ok) begin
                        pc_d    = redirect_pc;
                        state_d = S_REQ;
                    end else if (inst_ready) begin
                        state_d = S_REQ;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            inst_q      <= 32'd0;
            inst_pc_q   <= '0;
            discard_q   <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            discard_q   <= discard_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed stimulus, behavioural reference model, per-cycle compare.
// Latency: memory responder has programmable latency (cycles after request acceptance).
// Backpressure: decode readiness and memory readiness are driven directly by the stimulus.
module tb_inst_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        fetch_err;

    inst_fetch_unit #(.XLEN(64), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_err       (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h8000_0000: mem_word = 32'h0010_0093;
            64'h8000_0004: mem_word = 32'h0000_0297;
            64'h8000_0008: mem_word = 32'h0010_0073;
            default:       mem_word = a[31:0] ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Memory responder: one response, mem_lat cycles after request acceptance
    int          mem_lat   = 1;
    int          pend_cnt  = 0;
    logic [63:0] pend_addr = 64'd0;
    logic        rsp_hs;
    logic [63:0] rsp_a;

    always @(posedge clk) begin
        rsp_hs = imem_req_valid && imem_req_ready && !rst;
        rsp_a  = imem_req_addr;
        #1;
        imem_resp_valid = 1'b0;
        if (rsp_hs) begin
            pend_cnt  = mem_lat;
            pend_addr = rsp_a;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend_addr);
            end
        end
    end

    // Transaction monitor: accepted requests and consumed instructions
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } cons_t;

    cons_t       cons_q[$];
    int          req_cnt       = 0;
    logic [63:0] last_req_addr = 64'd0;

    always @(posedge clk) begin
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
                req_cnt++;
                last_req_addr = imem_req_addr;
            end
            if (inst_valid && inst_ready) begin
                cons_q.push_back({inst_pc, inst});
            end
        end
    end

    // Reference model: tracks whether a fetch is outstanding, whether its data is stale,
    // and whether a word is being offered to decode.
    logic        m_on    = 1'b0;
    logic [63:0] m_pc    = 64'd0;
    logic        m_out   = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_held  = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_inst  = 32'd0;
    logic [63:0] m_ipc   = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1; m_pc = RESET_PC; m_out = 1'b0; m_stale = 1'b0;
            m_held = 1'b0; m_err = 1'b0; m_inst = 32'd0; m_ipc = 64'd0;
        end else if (m_on && !m_err) begin
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                m_err  = 1'b1;
                m_held = 1'b0;
            end else if (redirect_valid) begin
                m_pc = redirect_pc;
                if (m_held) begin
                    m_held = 1'b0;
                end else if (m_out) begin
                    if (imem_resp_valid) begin
                        m_out = 1'b0; m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    m_out = 1'b1; m_stale = 1'b1;
                end
            end else begin
                if (m_held) begin
                    if (inst_ready) m_held = 1'b0;
                end else if (m_out) begin
                    if (imem_resp_valid) begin
                        m_out = 1'b0;
                        if (m_stale) begin
                            m_stale = 1'b0;
                        end else begin
                            m_held = 1'b1;
                            m_inst = imem_resp_data;
                            m_ipc  = m_pc;
                            m_pc   = m_pc + 64'd4;
                        end
                    end
                end else if (imem_req_ready) begin
                    m_out = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_on) begin
            check("req_valid", imem_req_valid, !m_err && !m_out && !m_held);
            if (!m_err && !m_out && !m_held) check("req_addr", imem_req_addr, m_pc);
            check("inst_valid", inst_valid, m_held && !m_err);
            check("inst", inst, m_inst);
            check("inst_pc", inst_pc, m_ipc);
            check("fetch_err", fetch_err, m_err);
        end
    end

    task automatic wait_req_hs(input int maxc, input string name);
        int c0;
        c0 = req_cnt;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (req_cnt != c0) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for request handshake", name);
    endtask

    task automatic wait_inst_valid(input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            if (inst_valid) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for inst_valid", name);
    endtask

    initial begin
        // 1: reset for two cycles
        step();
        step();
        rst = 1'b0;
        check("t1_req_valid", imem_req_valid, 1'b1);
        check("t1_req_addr", imem_req_addr, 64'h8000_0000);
        check("t1_inst_valid", inst_valid, 1'b0);
        check("t1_fetch_err", fetch_err, 1'b0);
        check("t1_inst_pc", inst_pc, 64'd0);

        // 2: three back-to-back fetches with 1-cycle memory
        for (int i = 0; i < 40 && cons_q.size() < 3; i++) step();
        check("t2_count", cons_q.size(), 3);
        if (cons_q.size() >= 3) begin
            check("t2_pc0", cons_q[0].pc, 64'h8000_0000);
            check("t2_in0", cons_q[0].ins, 32'h0010_0093);
            check("t2_pc1", cons_q[1].pc, 64'h8000_0004);
            check("t2_in1", cons_q[1].ins, 32'h0000_0297);
            check("t2_pc2", cons_q[2].pc, 64'h8000_0008);
            check("t2_in2", cons_q[2].ins, 32'h0010_0073);
        end

        // 3: decode stalls for 5 cycles
        inst_ready = 1'b0;
        wait_inst_valid(20, "t3_wait");
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", inst_valid, 1'b1);
            check("t3_hold_pc", inst_pc, 64'h8000_000C);
            check("t3_hold_inst", inst, 32'h9357_9BD3);
            check("t3_hold_noreq", imem_req_valid, 1'b0);
        end
        mem_lat    = 3;
        inst_ready = 1'b1;
        wait_req_hs(10, "t3_release");
        check("t3_next_addr", last_req_addr, 64'h8000_0010);

        // 4: redirect while waiting on a 3-cycle response
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        wait_req_hs(20, "t4_redir_wait");
        check("t4_req_addr", last_req_addr, 64'h8000_0100);
        check("t4_dropped", cons_q.size(), 4);
        wait_inst_valid(20, "t4_inst");
        check("t4_inst_pc", inst_pc, 64'h8000_0100);
        check("t4_inst", inst, 32'h9357_9ADF);
        // redirect in HOLD while decode is taking the word
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        check("t4_hold_drop", inst_valid, 1'b0);
        check("t4_consumed", cons_q.size(), 5);
        wait_req_hs(10, "t4_refetch");
        check("t4_refetch_addr", last_req_addr, 64'h8000_0100);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_inst_valid(30, "t7_inst");
        check("t7_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_req_hs(10, "t7_wrap");
        check("t7_wrap_addr", last_req_addr, 64'd0);

        // 5: misaligned redirect -> sticky error
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                redirect_valid = 1'b1;
                redirect_pc    = 64'h8000_0200;
            end else begin
                redirect_valid = 1'b0;
            end
            check("t5_err", fetch_err, 1'b1);
            check("t5_noreq", imem_req_valid, 1'b0);
            check("t5_noinst", inst_valid, 1'b0);
            step();
        end
        redirect_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_err", fetch_err, 1'b0);
        check("t5_rst_req", imem_req_valid, 1'b1);
        check("t5_rst_addr", imem_req_addr, 64'h8000_0000);

        // 6: reset while a fetch is outstanding; stale response arrives afterwards
        wait_req_hs(10, "t6_req");
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_stale_ignored", inst_valid, 1'b0);
        end
        check("t6_req_valid", imem_req_valid, 1'b1);
        check("t6_req_addr", imem_req_addr, 64'h8000_0000);
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        wait_inst_valid(20, "t6_inst");
        check("t6_inst_pc", inst_pc, 64'h8000_0000);
        check("t6_inst", inst, 32'h0010_0093);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
